// File: rtl/ow_bit_engine.sv
// 1-Wire master timing engine: reset/presence sequences and LSB-first write/read slots.
// Define OW_OVERDRIVE_EN to add the od port and the OD_* overdrive timing set.
module ow_bit_engine #(
  parameter int unsigned W          = 8,
  parameter int unsigned CLK_PER_US = 50,
  parameter int unsigned T_RSTL_US  = 480,
  parameter int unsigned T_PDS_US   = 70,
  parameter int unsigned T_RSTH_US  = 480,
  parameter int unsigned T_LOW1_US  = 6,
  parameter int unsigned T_LOW0_US  = 60,
  parameter int unsigned T_RDS_US   = 15,
  parameter int unsigned T_SLOT_US  = 70
`ifdef OW_OVERDRIVE_EN
  ,
  parameter int unsigned OD_RSTL_US = 70,
  parameter int unsigned OD_PDS_US  = 8,
  parameter int unsigned OD_RSTH_US = 70,
  parameter int unsigned OD_LOW1_US = 1,
  parameter int unsigned OD_LOW0_US = 8,
  parameter int unsigned OD_RDS_US  = 2,
  parameter int unsigned OD_SLOT_US = 10
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [$clog2(W+1)-1:0] cmd_len,
  input  logic [W-1:0]           cmd_data,
  output logic                   rsp_valid,
  output logic [W-1:0]           rsp_data,
  output logic                   rsp_presence,
  output logic                   rsp_error,
  output logic                   busy,
  output logic                   dq_oe,
`ifdef OW_OVERDRIVE_EN
  input  logic                   od,
`endif
  input  logic                   dq_in
);

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Write-0 low time never swallows the whole slot, so recovery is always non-zero.
  function automatic int unsigned low0_clamp(input int unsigned low0, input int unsigned slot);
    return (low0 > slot - 1) ? slot - 1 : low0;
  endfunction

  localparam int unsigned LW = $clog2(W+1);
`ifdef OW_OVERDRIVE_EN
  localparam int unsigned MAX_US = umax(umax(umax(T_RSTL_US, T_RSTH_US), T_SLOT_US),
                                        umax(umax(OD_RSTL_US, OD_RSTH_US), OD_SLOT_US));
`else
  localparam int unsigned MAX_US = umax(umax(T_RSTL_US, T_RSTH_US), T_SLOT_US);
`endif
  localparam int unsigned CW = $clog2(MAX_US * CLK_PER_US + 1);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_RESET = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [2:0] {IDLE, RST_LOW, RST_HIGH, SLOT_LOW, SLOT_HIGH, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic [W-1:0]  wdata_q, wdata_d, mask_q, mask_d, rd_q, rd_d;
  logic [LW-1:0] rem_q, rem_d;
  logic          pres_q, pres_d;
  logic [1:0]    sync_q;
  logic          dq_sync;
  logic          cmd_ready_q, cmd_ready_d, busy_q, busy_d, dq_oe_q, dq_oe_d;
  logic          rsp_valid_q, rsp_valid_d, rsp_presence_q, rsp_presence_d;
  logic          rsp_error_q, rsp_error_d;
  logic [W-1:0]  rsp_data_q, rsp_data_d;
  logic [CW-1:0] t_rstl, t_pds, t_rsth, t_low1, t_low0, t_rds, t_slot, low_cur;
  logic [CW:0]   slot_pos;
`ifdef OW_OVERDRIVE_EN
  logic          od_q, od_d;
`endif

  assign dq_sync = sync_q[1];

  always_comb begin
    t_rstl = CW'(T_RSTL_US * CLK_PER_US);
    t_pds  = CW'(T_PDS_US * CLK_PER_US);
    t_rsth = CW'(T_RSTH_US * CLK_PER_US);
    t_low1 = CW'(T_LOW1_US * CLK_PER_US);
    t_low0 = CW'(low0_clamp(T_LOW0_US, T_SLOT_US) * CLK_PER_US);
    t_rds  = CW'(T_RDS_US * CLK_PER_US);
    t_slot = CW'(T_SLOT_US * CLK_PER_US);
`ifdef OW_OVERDRIVE_EN
    if (od_q) begin
      t_rstl = CW'(OD_RSTL_US * CLK_PER_US);
      t_pds  = CW'(OD_PDS_US * CLK_PER_US);
      t_rsth = CW'(OD_RSTH_US * CLK_PER_US);
      t_low1 = CW'(OD_LOW1_US * CLK_PER_US);
      t_low0 = CW'(low0_clamp(OD_LOW0_US, OD_SLOT_US) * CLK_PER_US);
      t_rds  = CW'(OD_RDS_US * CLK_PER_US);
      t_slot = CW'(OD_SLOT_US * CLK_PER_US);
    end
`endif
  end

  // The counter restarts in SLOT_HIGH, so slot position adds back the low phase length.
  always_comb begin
    low_cur  = (op_q == OP_WRITE && !wdata_q[0]) ? t_low0 : t_low1;
    slot_pos = {1'b0, cnt_q} + {1'b0, low_cur};
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q + CW'(1);
    op_d           = op_q;
    wdata_d        = wdata_q;
    mask_d         = mask_q;
    rd_d           = rd_q;
    rem_d          = rem_q;
    pres_d         = pres_q;
    dq_oe_d        = dq_oe_q;
    rsp_valid_d    = 1'b0;
    rsp_data_d     = rsp_data_q;
    rsp_presence_d = rsp_presence_q;
    rsp_error_d    = rsp_error_q;
`ifdef OW_OVERDRIVE_EN
    od_d           = od_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cmd_valid && cmd_ready_q) begin
          op_d    = cmd_op;
          wdata_d = cmd_data;
          rem_d   = cmd_len;
          mask_d  = W'(1);
          rd_d    = '0;
          pres_d  = 1'b0;
`ifdef OW_OVERDRIVE_EN
          od_d    = od;
`endif
          if (cmd_op == OP_RSVD ||
              (cmd_op != OP_RESET && (cmd_len == '0 || cmd_len > LW'(W)))) begin
            state_d        = RESP;
            rsp_valid_d    = 1'b1;
            rsp_data_d     = '0;
            rsp_presence_d = 1'b0;
            rsp_error_d    = 1'b1;
          end else begin
            state_d = (cmd_op == OP_RESET) ? RST_LOW : SLOT_LOW;
            dq_oe_d = 1'b1;
          end
        end
      end
      RST_LOW: begin
        if (cnt_q == t_rstl - CW'(1)) begin
          state_d = RST_HIGH;
          dq_oe_d = 1'b0;
        end
      end
      RST_HIGH: begin
        if (cnt_q == t_pds) pres_d = !dq_sync;
        if (cnt_q == t_rsth - CW'(1)) begin
          state_d        = RESP;
          rsp_valid_d    = 1'b1;
          rsp_data_d     = '0;
          rsp_presence_d = pres_d;
          rsp_error_d    = 1'b0;
        end
      end
      SLOT_LOW: begin
        if (cnt_q == low_cur - CW'(1)) begin
          state_d = SLOT_HIGH;
          dq_oe_d = 1'b0;
        end
      end
      SLOT_HIGH: begin
        if (op_q == OP_READ && slot_pos == {1'b0, t_rds} && dq_sync) rd_d = rd_q | mask_q;
        if (slot_pos == {1'b0, t_slot} - (CW+1)'(1)) begin
          if (rem_q == LW'(1)) begin
            state_d        = RESP;
            rsp_valid_d    = 1'b1;
            rsp_data_d     = (op_q == OP_READ) ? rd_d : '0;
            rsp_presence_d = 1'b0;
            rsp_error_d    = 1'b0;
          end else begin
            state_d = SLOT_LOW;
            rem_d   = rem_q - LW'(1);
            mask_d  = mask_q << 1;
            wdata_d = wdata_q >> 1;
            dq_oe_d = 1'b1;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      op_q           <= '0;
      wdata_q        <= '0;
      mask_q         <= '0;
      rd_q           <= '0;
      rem_q          <= '0;
      pres_q         <= 1'b0;
      sync_q         <= '1;
      cmd_ready_q    <= 1'b1;
      busy_q         <= 1'b0;
      dq_oe_q        <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_presence_q <= 1'b0;
      rsp_error_q    <= 1'b0;
`ifdef OW_OVERDRIVE_EN
      od_q           <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      op_q           <= op_d;
      wdata_q        <= wdata_d;
      mask_q         <= mask_d;
      rd_q           <= rd_d;
      rem_q          <= rem_d;
      pres_q         <= pres_d;
      sync_q         <= {sync_q[0], dq_in};
      cmd_ready_q    <= cmd_ready_d;
      busy_q         <= busy_d;
      dq_oe_q        <= dq_oe_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_presence_q <= rsp_presence_d;
      rsp_error_q    <= rsp_error_d;
`ifdef OW_OVERDRIVE_EN
      od_q           <= od_d;
`endif
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign busy         = busy_q;
  assign dq_oe        = dq_oe_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_presence = rsp_presence_q;
  assign rsp_error    = rsp_error_q;

endmodule

// File: doc/ow_bit_engine.md
Name: ow_bit_engine

Overview:
Parameterised 1-Wire master timing engine. It executes reset/presence sequences and multi-bit write/read transactions of 1..W bits, LSB first. Timing is derived from clock cycles per microsecond. Sits between the 1-Wire command controller (valid/ready command and response channels) and the open-drain DQ pad.

Parameters:
W, 8, max bits per transaction (1..32)
CLK_PER_US, 50, clk cycles per microsecond
T_RSTL_US, 480, reset low time
T_PDS_US, 70, presence sample point after release
T_RSTH_US, 480, total high time after reset release
T_LOW1_US, 6, low time for write-1 and read slots
T_LOW0_US, 60, low time for write-0 slot
T_RDS_US, 15, read sample point from slot start
T_SLOT_US, 70, total slot length including recovery

Ports:
clk  in  1  clock
rst  in  1  reset
cmd_valid  in  1  command offered
cmd_ready  out  1  engine accepts command
cmd_op  in  2  00 write, 01 read, 10 reset, 11 reserved
cmd_len  in  $clog2(W+1)  bit count, 1..W (ignored for reset)
cmd_data  in  W  write data, bit 0 sent first
rsp_valid  out  1  one-cycle response strobe
rsp_data  out  W  read data, bit i = i-th sampled bit; unused MSBs 0
rsp_presence  out  1  presence detected (reset op only)
rsp_error  out  1  illegal command
busy  out  1  transaction in progress
dq_oe  out  1  1 = pull DQ low; 0 = release
dq_in  in  1  raw DQ pin level (asynchronous)

Behaviour:
- Reset is asynchronous and active-high; clock is clk.
- Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_presence=0, rsp_error=0, busy=0, dq_oe=0, state=IDLE.
- dq_in passes through a 2-FF synchroniser. All samples use the synchronised value, giving 2 cycles of latency.
- Handshake: cmd_ready=1 only in IDLE. A command is accepted on the cycle where cmd_valid && cmd_ready. cmd_op, cmd_len and cmd_data are latched on acceptance.
- Counter: a single timebase counter, wide enough for T_RSTL_US*CLK_PER_US. It resets to 0 on every state entry.
- States: IDLE, RST_LOW, RST_HIGH, SLOT_LOW, SLOT_HIGH, RESP.
- IDLE -> RST_LOW when op=10.
  - RST_LOW: dq_oe=1 for T_RSTL_US*CLK_PER_US cycles, then -> RST_HIGH.
  - RST_HIGH: dq_oe=0. At count T_PDS_US*CLK_PER_US, latch presence = !dq_sync. At count T_RSTH_US*CLK_PER_US-1, -> RESP.
- IDLE -> SLOT_LOW when op=00/01. Bit index starts at 0.
  - SLOT_LOW: dq_oe=1. Low time is T_LOW0 if op=write and current bit=0; otherwise T_LOW1. Then -> SLOT_HIGH.
  - SLOT_HIGH: dq_oe=0. For a read, sample dq_sync into rsp_data[idx] when the slot count reaches T_RDS_US*CLK_PER_US, measured from slot start. At slot end (T_SLOT_US total from slot start):
    - if idx==len-1, -> RESP;
    - else idx++ and -> SLOT_LOW.
- op=11, or len=0, or len>W: no DQ activity, -> RESP directly with rsp_error=1.
- RESP: rsp_valid=1 for exactly one cycle, then -> IDLE.
  - rsp_data is valid for reads and 0 for writes and resets.
  - rsp_presence is valid for resets and 0 otherwise.
  - rsp_data, rsp_presence and rsp_error hold until the next RESP.
- busy = (state != IDLE).
- Back-to-back commands: the earliest next acceptance is the cycle after RESP.
- Reset mid-operation releases DQ (dq_oe=0) immediately and asynchronously. No response is issued.
- Write-0 low time is clamped to at most T_SLOT-1us, so the recovery period is never zero.

Optional Feature:
Macro OW_OVERDRIVE_EN.
- Defined: adds input port od (1 bit), latched with each command. When od=1, overdrive timings are used in place of the standard set: RSTL 70us, PDS 8us, RSTH 70us, LOW1 1us, LOW0 8us, RDS 2us, SLOT 10us. These are exposed as extra parameters OD_* with those defaults.
- Undefined: no od port; standard timings only.

Test Plan:
- Reset op with a slave model pulling DQ low from 15us to 135us after release, at CLK_PER_US=50 -> dq_oe high for exactly 24000 cycles; rsp_presence=1; rsp_valid one cycle after 48000 total.
- Reset op with no slave -> rsp_presence=0, rsp_error=0.
- Write, len=8, data=0xA5 -> 8 slots of 3500 cycles each. Low widths in order: 300,3000,300,3000,3000,300,3000,300. rsp_data=0.
- Read, len=4, slave returns bits 1,0,1,1 -> rsp_data=0x0D; unused bits 0.
- op=11 and len=0 -> rsp_error=1 within 2 cycles of accept; dq_oe never asserted.
- Assert rst during SLOT_LOW -> dq_oe=0 in the same cycle; cmd_ready=1 after release; no rsp_valid.
